elevator_call_dispatcher: RTL and testbench
===========================================

// Module: elevator_call_dispatcher
// PURPOSE
//  Command-side counterpart of the elevator floor controller. Latches hall/cab call buttons
//  and reads the car position from the controller's one-hot floor LEDs. Drives the
//  controller's Enable/Up_Down inputs one floor step at a time and runs the door dwell.
//  Sits between the call-button inputs and the floor controller; 3 floors (1..3).
// PARAMETERS
//  DOOR_CYCLES    8   cycles door_open is held at a served floor (>=1)
//  MOVE_TIMEOUT   16  cycles to wait for a floor change after a step command before fault
// PORTS
//  CLK          in   1  clock, all logic on rising edge
//  RST          in   1  reset, synchronous, active-high
//  call_req     in   3  call buttons, bit0=floor1..bit2=floor3, level, OR'd into pending
//  floor_leds   in   3  car position from controller {LED_C,LED_B,LED_A}, must be one-hot
//  Enable       out  1  step strobe to controller, single-cycle pulse
//  Up_Down      out  2  2'b01 up, 2'b10 down, 2'b00 hold; valid with Enable
//  door_open    out  1  door held open at current floor
//  pending      out  3  latched unserved requests
//  fault        out  1  sticky: invalid floor_leds or move timeout
// BEHAVIOUR
//  - Reset (RST=1 at CLK edge): state IDLE, Enable=0, Up_Down=2'b00, door_open=0,
//    pending=3'b000, fault=0, dir=UP, timers=0. RST mid-move aborts; no step issued after it.
//  - pending[i] <= (pending[i] | call_req[i]) & ~serve[i]; serve wins over call in same cycle.
//  - cur_floor decoded from floor_leds; any non-one-hot value -> FAULT next cycle.
//  - FSM states: IDLE, STEP, WAIT_ARRIVE, DOOR, FAULT.
//    IDLE: if pending[cur] -> DOOR (serve[cur]=1). Else if any pending: pick dir (SCAN:
//      keep dir while a request lies ahead, else reverse) -> STEP. Else stay.
//    STEP: Enable=1, Up_Down=dir code, for exactly one cycle; latch launch floor; clear
//      timer -> WAIT_ARRIVE.
//    WAIT_ARRIVE: Enable=0, Up_Down=00. When floor_leds differs from launch floor -> IDLE.
//      Timer reaches MOVE_TIMEOUT -> FAULT.
//    DOOR: door_open=1 for DOOR_CYCLES cycles, serve[cur] asserted every cycle
//      (re-press at same floor absorbed); then -> IDLE, door_open=0.
//    FAULT: Enable=0, Up_Down=00, door_open=0, fault=1; exits only on RST.
//  - Never issue up at floor3 or down at floor1 (SCAN forces reversal there).
//  - Latency: call at idle car one floor away -> Enable pulse 2 cycles after call sampled.
//  - Enable only asserted in STEP; Up_Down is 00 whenever Enable=0.
// CONFIGURATION
//  EMERGENCY_RECALL_EN defined: extra input emergency_recall (1b). While high: pending
//    forced to 000, call_req ignored, car stepped down to floor1, then DOOR held open
//    indefinitely (no dwell count) until emergency_recall drops; a recall during
//    WAIT_ARRIVE takes effect after arrival. FAULT still overrides.
//  Not defined: port absent, behaviour as above.
// STRUCTURE
//  - elevator_pkg: state enum, UD_UP=2'b01/UD_DOWN=2'b10/UD_HOLD=2'b00, FLOOR_1/2/3
//    one-hot LED codes; shared with the floor controller.
//  - Sub-module: elevator_door_timer (load/count/done, width from DOOR_CYCLES).
// TESTING
//  1 Reset, floor_leds=001, call_req=100 -> two STEP pulses Up_Down=01, door_open at
//    floor3 for 8 cycles, pending 000.
//  2 Car at 010, call_req=010 -> no Enable, door_open=1 for 8 cycles, pending[1] cleared.
//  3 Car at 010 moving up (dir=UP), calls 001 and 100 together -> serves 3 first then 1.
//  4 Step issued, floor_leds held unchanged 16 cycles -> fault=1, Enable stays 0 until RST.
//  5 floor_leds=011 in IDLE -> FAULT next cycle; RST=1 -> all outputs reset values.
//  6 (EMERGENCY_RECALL_EN) car at 100, pending 010, recall=1 -> pending 000, two Up_Down=10
//    steps, door_open held until recall=0, then door closes after exiting DOOR.

Source files
------------

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared types and encodings for the elevator floor controller
//                and its call dispatcher: FSM states, Up_Down command codes,
//                one-hot floor LED codes and small floor-mask helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package elevator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_STEP        = 3'd1,
        ST_WAIT_ARRIVE = 3'd2,
        ST_DOOR        = 3'd3,
        ST_FAULT       = 3'd4
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [1:0] UD_HOLD = 2'b00;
    localparam logic [1:0] UD_UP   = 2'b01;
    localparam logic [1:0] UD_DOWN = 2'b10;

    localparam logic [2:0] FLOOR_1 = 3'b001;
    localparam logic [2:0] FLOOR_2 = 3'b010;
    localparam logic [2:0] FLOOR_3 = 3'b100;

    function automatic logic is_one_hot3(input logic [2:0] v);
        return (v == FLOOR_1) || (v == FLOOR_2) || (v == FLOOR_3);
    endfunction

    // Floors strictly above the given car position.
    function automatic logic [2:0] above_mask(input logic [2:0] f);
        case (f)
            FLOOR_1: return 3'b110;
            FLOOR_2: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Floors strictly below the given car position.
    function automatic logic [2:0] below_mask(input logic [2:0] f);
        case (f)
            FLOOR_3: return 3'b011;
            FLOOR_2: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_call_dispatcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_call_dispatcher_if
//  Description : Signal bundle between call buttons / floor controller and the
//                call dispatcher.
//                  call_req[2:0]   call buttons (bit0 = floor 1)
//                  floor_leds[2:0] one-hot car position {LED_C,LED_B,LED_A}
//                  Enable          single-cycle step strobe
//                  Up_Down[1:0]    01 up, 10 down, 00 hold
//                  door_open       door held open
//                  pending[2:0]    latched unserved requests
//                  fault           sticky fault flag
//                  emergency_recall (only with EMERGENCY_RECALL_EN)
//                slave  = dispatcher view, master = environment view.
//  Config      : EMERGENCY_RECALL_EN adds emergency_recall.
//  Revision    : 1.0  initial release
// ============================================================================
interface elevator_call_dispatcher_if;
    logic [2:0] call_req;
    logic [2:0] floor_leds;
`ifdef EMERGENCY_RECALL_EN
    logic       emergency_recall;
`endif
    logic       Enable;
    logic [1:0] Up_Down;
    logic       door_open;
    logic [2:0] pending;
    logic       fault;

`ifdef EMERGENCY_RECALL_EN
    modport master (
        output call_req, floor_leds, emergency_recall,
        input  Enable, Up_Down, door_open, pending, fault
    );
    modport slave (
        input  call_req, floor_leds, emergency_recall,
        output Enable, Up_Down, door_open, pending, fault
    );
`else
    modport master (
        output call_req, floor_leds,
        input  Enable, Up_Down, door_open, pending, fault
    );
    modport slave (
        input  call_req, floor_leds,
        output Enable, Up_Down, door_open, pending, fault
    );
`endif
endinterface
`default_nettype wire

// File: rtl/elevator_door_timer.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_door_timer
//  Description : Door dwell down-counter. load presets DOOR_CYCLES-1, clear
//                forces zero, count decrements while non-zero; done is high
//                when the count is zero.
//  Ports       : CLK, RST (sync, active-high), load, clear, count -> done
//  Revision    : 1.0  initial release
// ============================================================================
module elevator_door_timer #(
    parameter int DOOR_CYCLES = 8
) (
    input  wire logic CLK,
    input  wire logic RST,
    input  wire logic load,
    input  wire logic clear,
    input  wire logic count,
    output logic      done
);
    localparam int c_width = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [c_width-1:0] c_load_val = c_width'(DOOR_CYCLES - 1);

    logic [c_width-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_load_val;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign done = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/elevator_call_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_call_dispatcher
//  Description : Latches call buttons, reads the car position from one-hot
//                floor LEDs, issues one-floor step strobes (SCAN ordering) to
//                the floor controller and runs the door dwell. Sticky fault on
//                invalid LEDs or a step that never arrives.
//  Ports       : CLK, RST (sync, active-high),
//                bus (slave): call_req, floor_leds in;
//                             Enable, Up_Down, door_open, pending, fault out.
//  Parameters  : DOOR_CYCLES  door dwell length in cycles (>=1)
//                MOVE_TIMEOUT cycles allowed for a floor change after a step
//  Config      : EMERGENCY_RECALL_EN enables emergency_recall: clears/blocks
//                calls, sends the car to floor 1 and holds the door open.
//  Revision    : 1.0  initial release
// ============================================================================
module elevator_call_dispatcher
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES  = 8,
    parameter int MOVE_TIMEOUT = 16
) (
    input  wire logic                 CLK,
    input  wire logic                 RST,
    elevator_call_dispatcher_if.slave bus
);
    localparam int c_tmr_w = $clog2(MOVE_TIMEOUT + 1);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(MOVE_TIMEOUT - 1);

    state_t             r_state;
    dir_t               r_dir;
    logic [2:0]         r_pending;
    logic [2:0]         r_launch;
    logic [c_tmr_w-1:0] r_move_timer;
    logic               r_enable;
    logic [1:0]         r_up_down;
    logic               r_door_open;
    logic               r_fault;

    logic [2:0] w_leds;
    logic       w_leds_ok;
    logic       w_recall;
    logic [2:0] w_serve;
    logic [2:0] w_pending_nxt;
    logic       w_ahead_up;
    logic       w_ahead_down;
    dir_t       w_next_dir;
    logic       w_idle_open;
    logic       w_hold;
    logic       w_door_count;
    logic       w_door_done;

    assign w_leds    = bus.floor_leds;
    assign w_leds_ok = is_one_hot3(w_leds);

`ifdef EMERGENCY_RECALL_EN
    assign w_recall = bus.emergency_recall;
`else
    assign w_recall = 1'b0;
`endif

    // IDLE opens the door when the car already sits at a requested floor,
    // or (during recall) once it has reached floor 1.
    assign w_idle_open = (r_state == ST_IDLE) && w_leds_ok &&
                         (w_recall ? (w_leds == FLOOR_1) : (|(r_pending & w_leds)));

    // Recall at floor 1 keeps the door open with no dwell count; holding the
    // timer at zero lets the door close as soon as recall drops.
    assign w_hold       = w_recall && (r_state == ST_DOOR) && (w_leds == FLOOR_1);
    assign w_door_count = (r_state == ST_DOOR);

    always_comb begin
        w_serve = 3'b000;
        if (w_leds_ok) begin
            if ((r_state == ST_IDLE) && !w_recall) begin
                w_serve = r_pending & w_leds;
            end else if (r_state == ST_DOOR) begin
                w_serve = w_leds;
            end
        end
    end

    // Serve beats a simultaneous press of the same floor.
    always_comb begin
        w_pending_nxt = (r_pending | bus.call_req) & ~w_serve;
        if (w_recall) begin
            w_pending_nxt = 3'b000;
        end
    end

    // SCAN: keep going while something is ahead, otherwise reverse. With no
    // floor above 3 or below 1 this also forbids up at 3 and down at 1.
    assign w_ahead_up   = |(r_pending & above_mask(w_leds));
    assign w_ahead_down = |(r_pending & below_mask(w_leds));

    always_comb begin
        w_next_dir = r_dir;
        if (r_dir == DIR_UP) begin
            w_next_dir = w_ahead_up ? DIR_UP : DIR_DOWN;
        end else begin
            w_next_dir = w_ahead_down ? DIR_DOWN : DIR_UP;
        end
    end

    elevator_door_timer #(
        .DOOR_CYCLES (DOOR_CYCLES)
    ) u_door_timer (
        .CLK   (CLK),
        .RST   (RST),
        .load  (w_idle_open),
        .clear (w_hold),
        .count (w_door_count),
        .done  (w_door_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_dir        <= DIR_UP;
            r_pending    <= 3'b000;
            r_launch     <= 3'b000;
            r_move_timer <= '0;
            r_enable     <= 1'b0;
            r_up_down    <= UD_HOLD;
            r_door_open  <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            // Step strobe is a one-cycle pulse; default it off every cycle.
            r_enable  <= 1'b0;
            r_up_down <= UD_HOLD;

            if ((r_state != ST_FAULT) && !w_leds_ok) begin
                r_state     <= ST_FAULT;
                r_fault     <= 1'b1;
                r_door_open <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_idle_open) begin
                            r_state     <= ST_DOOR;
                            r_door_open <= 1'b1;
                        end else if (w_recall) begin
                            // Not at floor 1 here, so down is always legal.
                            r_dir   <= DIR_DOWN;
                            r_state <= ST_STEP;
                        end else if (|r_pending) begin
                            r_dir   <= w_next_dir;
                            r_state <= ST_STEP;
                        end
                    end
                    ST_STEP: begin
                        r_enable     <= 1'b1;
                        r_up_down    <= (r_dir == DIR_UP) ? UD_UP : UD_DOWN;
                        r_launch     <= w_leds;
                        r_move_timer <= '0;
                        r_state      <= ST_WAIT_ARRIVE;
                    end
                    ST_WAIT_ARRIVE: begin
                        if (w_leds != r_launch) begin
                            r_state <= ST_IDLE;
                        end else if (r_move_timer == c_tmr_last) begin
                            r_state <= ST_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_move_timer <= r_move_timer + 1'b1;
                        end
                    end
                    ST_DOOR: begin
                        if (!w_hold && w_door_done) begin
                            r_state     <= ST_IDLE;
                            r_door_open <= 1'b0;
                        end
                    end
                    ST_FAULT: begin
                        r_fault     <= 1'b1;
                        r_door_open <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.Enable    = r_enable;
    assign bus.Up_Down   = r_up_down;
    assign bus.door_open = r_door_open;
    assign bus.pending   = r_pending;
    assign bus.fault     = r_fault;
endmodule
`default_nettype wire

// File: tb/tb_elevator_call_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elevator_call_dispatcher
//  Description : Self-checking bench for elevator_call_dispatcher. A small
//                floor-controller model answers step strobes; expected step
//                and door events are queued as stimulus is applied and popped
//                by a monitor as the dispatcher produces them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_elevator_call_dispatcher;
    import elevator_pkg::*;

    localparam int DOOR_CYCLES  = 8;
    localparam int MOVE_TIMEOUT = 16;

    typedef struct packed {
        logic       is_door;
        logic [2:0] val;
    } exp_t;

    logic CLK;
    logic RST;
    elevator_call_dispatcher_if bus ();

    elevator_call_dispatcher #(
        .DOOR_CYCLES  (DOOR_CYCLES),
        .MOVE_TIMEOUT (MOVE_TIMEOUT)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    bit   plant_en = 1'b1;
    bit   chk_len  = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_step(input logic [1:0] code);
        exp_t e;
        e.is_door = 1'b0;
        e.val     = {1'b0, code};
        sb.push_back(e);
    endtask

    task automatic push_door(input logic [2:0] floor);
        exp_t e;
        e.is_door = 1'b1;
        e.val     = floor;
        sb.push_back(e);
    endtask

    // Floor-controller model: moves the car one floor three cycles after a strobe.
    task automatic plant();
        int         cd = 0;
        logic [1:0] code = UD_HOLD;
        forever begin
            @(negedge CLK);
            if (RST || !plant_en) begin
                cd = 0;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    if (code == UD_UP) bus.floor_leds = bus.floor_leds << 1;
                    else               bus.floor_leds = bus.floor_leds >> 1;
                end
            end else if (bus.Enable) begin
                cd   = 3;
                code = bus.Up_Down;
            end
        end
    endtask

    task automatic monitor();
        logic prev_door = 1'b0;
        int   len = 0;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (!bus.Enable && (bus.Up_Down != UD_HOLD))
                    check_eq("updown_idle", {30'd0, bus.Up_Down}, {30'd0, UD_HOLD});
                if (bus.Enable) begin
                    if (sb.size() == 0) begin
                        check_eq("unexpected_step", {30'd0, bus.Up_Down}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("event_is_step", {31'd0, e.is_door}, 32'd0);
                        check_eq("step_updown", {30'd0, bus.Up_Down}, {30'd0, e.val[1:0]});
                    end
                end
                if (bus.door_open && !prev_door) begin
                    if (sb.size() == 0) begin
                        check_eq("unexpected_door", {29'd0, bus.floor_leds}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("event_is_door", {31'd0, e.is_door}, 32'd1);
                        check_eq("door_floor", {29'd0, bus.floor_leds}, {29'd0, e.val});
                    end
                end
                if (bus.door_open) begin
                    len++;
                end else if (prev_door) begin
                    if (chk_len) check_eq("door_len", len, DOOR_CYCLES);
                    len = 0;
                end
            end
            prev_door = bus.door_open;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_enable"},  {31'd0, bus.Enable},    32'd0);
        check_eq({tag, "_updown"},  {30'd0, bus.Up_Down},   32'd0);
        check_eq({tag, "_door"},    {31'd0, bus.door_open}, 32'd0);
        check_eq({tag, "_pending"}, {29'd0, bus.pending},   32'd0);
        check_eq({tag, "_fault"},   {31'd0, bus.fault},     32'd0);
    endtask

    task automatic pulse_call(input logic [2:0] c);
        @(negedge CLK);
        bus.call_req = c;
        @(negedge CLK);
        bus.call_req = 3'b000;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((sb.size() != 0 || bus.door_open) && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check_eq({tag, "_drained"}, sb.size(), 0);
        repeat (20) @(negedge CLK);
        check_eq({tag, "_pending"}, {29'd0, bus.pending}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        RST            = 1'b1;
        bus.call_req   = 3'b000;
        bus.floor_leds = FLOOR_1;
`ifdef EMERGENCY_RECALL_EN
        bus.emergency_recall = 1'b0;
`endif
        fork
            plant();
            monitor();
        join_none

        // Reset state
        do_reset();
        check_reset_outputs("reset");

        // T1: car at floor 1, call floor 3: two up steps, door at floor 3.
        push_step(UD_UP);
        push_step(UD_UP);
        push_door(FLOOR_3);
        @(negedge CLK);
        bus.call_req = 3'b100;
        @(posedge CLK); #1;
        bus.call_req = 3'b000;
        check_eq("lat_edge0", {31'd0, bus.Enable}, 32'd0);
        check_eq("pending_latched", {29'd0, bus.pending}, 32'b100);
        @(posedge CLK); #1;
        check_eq("lat_edge1", {31'd0, bus.Enable}, 32'd0);
        @(posedge CLK); #1;
        check_eq("lat_edge2", {31'd0, bus.Enable}, 32'd1);
        wait_idle("t1");

        // T2: car at floor 2 with a call there: door only, re-press absorbed.
        @(negedge CLK);
        bus.floor_leds = FLOOR_2;
        push_door(FLOOR_2);
        pulse_call(3'b010);
        n = 0;
        while (!bus.door_open && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check_eq("t2_door_opened", {31'd0, bus.door_open}, 32'd1);
        repeat (2) @(negedge CLK);
        pulse_call(3'b010);
        wait_idle("t2");

        // T3: at floor 2 heading up, calls 1 and 3: floor 3 first, then 1.
        push_step(UD_UP);
        push_door(FLOOR_3);
        push_step(UD_DOWN);
        push_step(UD_DOWN);
        push_door(FLOOR_1);
        pulse_call(3'b101);
        wait_idle("t3");

        // T4: step that never arrives -> fault, no further strobes.
        plant_en = 1'b0;
        push_step(UD_UP);
        @(negedge CLK);
        bus.call_req = 3'b010;
        @(posedge CLK); #1;
        bus.call_req = 3'b000;
        n = 0;
        while (!bus.Enable && n < 10) begin
            @(posedge CLK); #1;
            n++;
        end
        check_eq("t4_step_seen", {31'd0, bus.Enable}, 32'd1);
        repeat (14) @(posedge CLK);
        #1;
        check_eq("t4_no_early_fault", {31'd0, bus.fault}, 32'd0);
        n = 0;
        while (!bus.fault && n < 3) begin
            @(posedge CLK); #1;
            n++;
        end
        check_eq("t4_timeout_fault", {31'd0, bus.fault}, 32'd1);
        repeat (20) @(negedge CLK);
        check_eq("t4_fault_sticky", {31'd0, bus.fault}, 32'd1);
        check_eq("t4_enable_low", {31'd0, bus.Enable}, 32'd0);
        check_eq("t4_sb_empty", sb.size(), 0);
        do_reset();
        check_reset_outputs("t4_reset");
        plant_en = 1'b1;

        // T5: non-one-hot LEDs in IDLE -> fault on the next edge.
        @(negedge CLK);
        check_eq("t5_pre_fault", {31'd0, bus.fault}, 32'd0);
        bus.floor_leds = 3'b011;
        @(posedge CLK); #1;
        check_eq("t5_fault", {31'd0, bus.fault}, 32'd1);
        check_eq("t5_enable", {31'd0, bus.Enable}, 32'd0);
        @(negedge CLK);
        bus.floor_leds = FLOOR_1;
        do_reset();
        check_reset_outputs("t5_reset");

`ifdef EMERGENCY_RECALL_EN
        // T6: recall from floor 3 with a pending call: two down steps, door held.
        chk_len = 1'b0;
        @(negedge CLK);
        bus.floor_leds = FLOOR_3;
        push_step(UD_DOWN);
        push_step(UD_DOWN);
        push_door(FLOOR_1);
        @(negedge CLK);
        bus.call_req = 3'b010;
        @(negedge CLK);
        bus.call_req = 3'b000;
        bus.emergency_recall = 1'b1;
        repeat (2) @(negedge CLK);
        check_eq("t6_pending_cleared", {29'd0, bus.pending}, 32'd0);
        n = 0;
        while (!bus.door_open && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check_eq("t6_door_opened", {31'd0, bus.door_open}, 32'd1);
        repeat (20) @(negedge CLK);
        check_eq("t6_door_held", {31'd0, bus.door_open}, 32'd1);
        bus.emergency_recall = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("t6_door_closed", {31'd0, bus.door_open}, 32'd0);
        check_eq("t6_sb_empty", sb.size(), 0);
        chk_len = 1'b1;
`endif

        repeat (5) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
